instruction_fetch_unit: RTL and testbench

Consumer and sequencer for the `program_counter` register in the Mini-MIPS front end. It reads the current PC and drives the register's next value (hold, +4, redirect, or reset vector). It fetches instruction words from instruction memory over a valid/ready request and response interface. Fetched words go into a 2-entry buffer that the decode stage drains through a valid/ready handshake.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 97 +++++++++
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the Mini-MIPS front end: fetch FSM states,
// PC step size, default reset vector and a PC alignment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_FAULT    = 2'd3
  } ifu_state_e;

  localparam logic [31:0] PC_INCREMENT         = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // True when the two low PC bits select a word boundary.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between fetch and decode. The head entry lives
// in dedicated registers so the decode-facing outputs come straight from flops.
// A flush empties the buffer and wins over a push or pop in the same cycle.
module fetch_buffer #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [PC_WIDTH-1:0]   push_pc,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [1:0]            count,
  output logic                  head_valid,
  output logic [PC_WIDTH-1:0]   head_pc,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [1:0]            count_r, count_next_s;
  logic                  head_valid_r;
  logic [PC_WIDTH-1:0]   head_pc_r, head_pc_next_s, tail_pc_r, tail_pc_next_s;
  logic [DATA_WIDTH-1:0] head_data_r, head_data_next_s, tail_data_r, tail_data_next_s;
  logic                  pop_s, push_s;

  // Work out the next occupancy and entry contents for push/pop/flush.
  always_comb begin
    count_next_s     = count_r;
    head_pc_next_s   = head_pc_r;
    head_data_next_s = head_data_r;
    tail_pc_next_s   = tail_pc_r;
    tail_data_next_s = tail_data_r;
    pop_s            = pop & head_valid_r;
    push_s           = push & ((count_r != 2'd2) | pop_s);
    if (flush) begin
      count_next_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_pc_next_s   = push_pc;
            head_data_next_s = push_data;
          end else begin
            tail_pc_next_s   = push_pc;
            tail_data_next_s = push_data;
          end
          count_next_s = count_r + 2'd1;
        end
        2'b01: begin
          head_pc_next_s   = tail_pc_r;
          head_data_next_s = tail_data_r;
          count_next_s     = count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_pc_next_s   = push_pc;
            head_data_next_s = push_data;
          end else begin
            head_pc_next_s   = tail_pc_r;
            head_data_next_s = tail_data_r;
            tail_pc_next_s   = push_pc;
            tail_data_next_s = push_data;
          end
        end
        default: begin
          count_next_s = count_r;
        end
      endcase
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r      <= 2'd0;
      head_valid_r <= 1'b0;
      head_pc_r    <= '0;
      head_data_r  <= '0;
      tail_pc_r    <= '0;
      tail_data_r  <= '0;
    end else begin
      count_r      <= count_next_s;
      head_valid_r <= (count_next_s != 2'd0);
      head_pc_r    <= head_pc_next_s;
      head_data_r  <= head_data_next_s;
      tail_pc_r    <= tail_pc_next_s;
      tail_data_r  <= tail_data_next_s;
    end
  end

  assign count      = count_r;
  assign head_valid = head_valid_r;
  assign head_pc    = head_pc_r;
  assign head_data  = head_data_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Mini-MIPS instruction fetch unit. Sequences the external program_counter
// register (drives its D from its Q), issues one outstanding fetch at a time
// and queues returned words in a 2-entry buffer drained by decode.
// Optional feature: define IFU_MISALIGN_TRAP_EN to trap on a misaligned PC
// (adds the fetch_fault port); otherwise the fetch address is word-masked.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int                   BUS_WIDTH    = 32,
  parameter int                   INSTR_WIDTH  = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = BUS_WIDTH'(RESET_VECTOR_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BUS_WIDTH-1:0]   pc_q,
  output logic [BUS_WIDTH-1:0]   pc_d,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [BUS_WIDTH-1:0]   imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [BUS_WIDTH-1:0]   redirect_target,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [BUS_WIDTH-1:0]   instr_pc
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic                   fetch_fault
`endif
);

  localparam logic [BUS_WIDTH-1:0] PC_STEP = BUS_WIDTH'(PC_INCREMENT);

  ifu_state_e           state_r, state_next_s;
  logic                 drop_r, drop_next_s;
  logic [BUS_WIDTH-1:0] inflight_pc_r;
  logic [1:0]           count_s;
  logic                 misaligned_s;
  logic                 req_valid_s;
  logic                 accept_s;
  logic                 push_s;

  // Request generation and PC sequencing; reset forces the reset vector.
  always_comb begin
`ifdef IFU_MISALIGN_TRAP_EN
    misaligned_s = !is_aligned(pc_q[1:0]);
    imem_addr    = pc_q;
`else
    misaligned_s = 1'b0;
    imem_addr    = {pc_q[BUS_WIDTH-1:2], 2'b00};
`endif
    req_valid_s    = (state_r == ST_REQ) && (count_s < 2'd2) && !misaligned_s;
    accept_s       = req_valid_s & imem_req_ready;
    imem_req_valid = req_valid_s;
    push_s         = (state_r == ST_WAIT_RSP) & imem_rsp_valid & ~drop_r;
    if (!rst_n) begin
      pc_d = RESET_VECTOR;
    end else if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (accept_s) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  // Next FSM state and the discard flag for a response made stale by a redirect.
  always_comb begin
    state_next_s = state_r;
    drop_next_s  = drop_r;
    case (state_r)
      ST_RESET: begin
        state_next_s = ST_REQ;
      end
      ST_REQ: begin
        if (accept_s) begin
          state_next_s = ST_WAIT_RSP;
        end else if (misaligned_s && !redirect_valid) begin
          state_next_s = ST_FAULT;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT_RSP: begin
        if (imem_rsp_valid) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_WAIT_RSP;
        end
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_FAULT;
        end
      end
      default: begin
        state_next_s = ST_RESET;
      end
    endcase
    if ((state_r == ST_WAIT_RSP) && imem_rsp_valid) begin
      drop_next_s = 1'b0;
    end else if (redirect_valid && ((state_r == ST_WAIT_RSP) || accept_s)) begin
      drop_next_s = 1'b1;
    end else begin
      drop_next_s = drop_r;
    end
  end

  // FSM state, discard flag and the PC of the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RESET;
      drop_r        <= 1'b0;
      inflight_pc_r <= '0;
    end else begin
      state_r <= state_next_s;
      drop_r  <= drop_next_s;
      if (accept_s) begin
        inflight_pc_r <= pc_q;
      end
    end
  end

  fetch_buffer #(
    .PC_WIDTH   (BUS_WIDTH),
    .DATA_WIDTH (INSTR_WIDTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_pc    (inflight_pc_r),
    .push_data  (imem_rsp_data),
    .pop        (instr_ready),
    .flush      (redirect_valid),
    .count      (count_s),
    .head_valid (instr_valid),
    .head_pc    (instr_pc),
    .head_data  (instr_data)
  );

`ifdef IFU_MISALIGN_TRAP_EN
  assign fetch_fault = (state_r == ST_FAULT);
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural program_counter
// register and a 1-cycle-latency instruction memory whose word is addr ^ 0xDEAD0000.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        mem_ready;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pcd;
    logic        valid;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_q            (pc_q),
    .pc_d            (pc_d),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .fetch_fault     (fetch_fault)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_req_ready = mem_ready;

  // program_counter register (no reset of its own)
  always @(posedge clk) pc_q <= pc_d;

  // instruction memory, one-cycle response latency
  always @(posedge clk) begin
    imem_rsp_valid <= imem_req_valid & imem_req_ready;
    imem_rsp_data  <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the bench 1 time unit after the last reset edge, rst_n released (cycle 0).
  task automatic do_reset(input logic rdy);
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    mem_ready       = 1'b1;
    instr_ready     = rdy;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h0, 32'h4,  1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h0, 32'h4,  1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 32'h4, 32'h8,  1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h0, 32'h8,  1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 32'h8, 32'hC,  1'b1, 32'h4};
    tbl[6] = '{1'b1, 1'b0, 32'h0, 32'hC,  1'b0, 32'h0};
    tbl[7] = '{1'b1, 1'b1, 32'hC, 32'h10, 1'b1, 32'h8};

    // Reset values while rst_n is held low
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    mem_ready = 1'b1; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_req", imem_req_valid, 1'b0);
    chk("rst_pcd", pc_d, 32'h0);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("rst_fault", fetch_fault, 1'b0);
`endif

    // Streaming fetch from the reset vector
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      instr_ready = tbl[i].rdy;
      sample();
      chk($sformatf("t%0d_req", i), imem_req_valid, tbl[i].req);
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_pcd", i), pc_d, tbl[i].pcd);
      chk($sformatf("t%0d_valid", i), instr_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("t%0d_ipc", i), instr_pc, tbl[i].ipc);
        chk($sformatf("t%0d_data", i), instr_data, mem_word(tbl[i].ipc));
      end
    end

    // Decode stalled: buffer fills with exactly two words and the PC holds
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) next_cycle();
    sample();
    chk("full_valid", instr_valid, 1'b1);
    chk("full_pc", instr_pc, 32'h0);
    chk("full_req", imem_req_valid, 1'b0);
    chk("full_pcq", pc_q, 32'h8);
    chk("full_pcd", pc_d, 32'h8);
    next_cycle(); instr_ready = 1'b1; sample();
    chk("drain0_pc", instr_pc, 32'h0);
    chk("drain0_data", instr_data, mem_word(32'h0));
    next_cycle(); sample();
    chk("drain1_valid", instr_valid, 1'b1);
    chk("drain1_pc", instr_pc, 32'h4);
    chk("drain1_req", imem_req_valid, 1'b1);
    chk("drain1_addr", imem_addr, 32'h8);
    next_cycle(); sample();
    chk("drain2_valid", instr_valid, 1'b0);
    next_cycle(); sample();
    chk("drain3_pc", instr_pc, 32'h8);

    // Redirect in the same cycle as an accept: the in-flight word is dropped
    do_reset(1'b1);
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'h100; sample();
    chk("rd_acc_req", imem_req_valid, 1'b1);
    chk("rd_acc_pcd", pc_d, 32'h100);
    next_cycle(); redirect_valid = 1'b0; sample();
    chk("rd_w_pcq", pc_q, 32'h100);
    chk("rd_w_valid", instr_valid, 1'b0);
    chk("rd_w_req", imem_req_valid, 1'b0);
    next_cycle(); sample();
    chk("rd_drop_valid", instr_valid, 1'b0);
    chk("rd_new_addr", imem_addr, 32'h100);
    next_cycle(); sample();
    chk("rd_c4_valid", instr_valid, 1'b0);
    next_cycle(); sample();
    chk("rd_c5_valid", instr_valid, 1'b1);
    chk("rd_c5_pc", instr_pc, 32'h100);
    chk("rd_c5_data", instr_data, mem_word(32'h100));

    // Redirect to a misaligned target while the buffer is full
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) next_cycle();
    redirect_valid = 1'b1; redirect_target = 32'h102; sample();
    chk("ma_pcd", pc_d, 32'h102);
    chk("ma_full_valid", instr_valid, 1'b1);
    next_cycle(); redirect_valid = 1'b0; sample();
    chk("ma_flush_valid", instr_valid, 1'b0);
    chk("ma_pcq", pc_q, 32'h102);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("ma_req", imem_req_valid, 1'b0);
    next_cycle(); sample();
    chk("ma_fault", fetch_fault, 1'b1);
    chk("ma_fault_req", imem_req_valid, 1'b0);
    chk("ma_fault_pcd", pc_d, 32'h102);
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'h200; sample();
    chk("ma_clr_pcd", pc_d, 32'h200);
    next_cycle(); redirect_valid = 1'b0; sample();
    chk("ma_clr_fault", fetch_fault, 1'b0);
    chk("ma_clr_req", imem_req_valid, 1'b1);
    chk("ma_clr_addr", imem_addr, 32'h200);
    next_cycle(); next_cycle(); sample();
    chk("ma_res_pc", instr_pc, 32'h200);
`else
    chk("ma_req", imem_req_valid, 1'b1);
    chk("ma_addr", imem_addr, 32'h100);
    chk("ma_inc", pc_d, 32'h106);
    next_cycle(); next_cycle(); sample();
    chk("ma_valid", instr_valid, 1'b1);
    chk("ma_ipc", instr_pc, 32'h102);
    chk("ma_data", instr_data, mem_word(32'h100));
`endif

    // Memory stalls the request, then a redirect to the last word wraps the PC
    do_reset(1'b1);
    mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); sample();
      chk($sformatf("st%0d_req", i), imem_req_valid, 1'b1);
      chk($sformatf("st%0d_addr", i), imem_addr, 32'h0);
      chk($sformatf("st%0d_pcq", i), pc_q, 32'h0);
      chk($sformatf("st%0d_pcd", i), pc_d, 32'h0);
    end
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; sample();
    chk("wr_pcd_rd", pc_d, 32'hFFFF_FFFC);
    next_cycle(); redirect_valid = 1'b0; mem_ready = 1'b1; sample();
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_pcd", pc_d, 32'h0);
    next_cycle(); sample();
    chk("wr_pcq", pc_q, 32'h0);
    chk("wr_req", imem_req_valid, 1'b0);
    next_cycle(); sample();
    chk("wr_valid", instr_valid, 1'b1);
    chk("wr_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_data", instr_data, mem_word(32'hFFFF_FFFC));

    // Reset pulse while a response is in flight
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) next_cycle();
    sample();
    chk("rp_pre_valid", instr_valid, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rp_valid", instr_valid, 1'b0);
    chk("rp_data", instr_data, 32'h0);
    chk("rp_pc", instr_pc, 32'h0);
    chk("rp_req", imem_req_valid, 1'b0);
    chk("rp_pcd", pc_d, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample();
    chk("rp_c0_pcq", pc_q, 32'h0);
    chk("rp_c0_valid", instr_valid, 1'b0);
    next_cycle(); next_cycle(); sample();
    chk("rp_c2_valid", instr_valid, 1'b0);
    next_cycle(); sample();
    chk("rp_c3_valid", instr_valid, 1'b1);
    chk("rp_c3_pc", instr_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
